// File: rtl/halt_watchdog.sv
// ---------------------------------------------------------------------------
// halt_watchdog
//
// Run-control monitor that decides when a simulation run ends and why.
// It watches NUM_CH commit/retire channels for halt requests, nonzero error
// codes, commit stalls and a global cycle timeout, and latches exactly one
// terminal status. After an error it waits DRAIN_CYCLES cycles before
// raising done, so the surrounding bench can flush outstanding traffic.
//
// Ports:
//   clk          - single clock
//   rst_n        - asynchronous active-low reset
//   start        - one-cycle pulse, IDLE -> RUN
//   commit       - per-channel commit valid            [NUM_CH]
//   halt         - per-channel halt flag               [NUM_CH]
//   errcode      - flat per-channel error codes, channel i at [i*ERR_W +: ERR_W]
//   running      - high while in RUN
//   done         - high in DONE, sticky until reset
//   status       - 0 NONE, 1 HALT, 2 TIMEOUT, 3 STALL, 4 ERROR
//   err_code     - latched error code of the reporting channel
//   err_ch       - index of the channel that raised the error
//   commit_count - total commits observed in RUN (saturating)
//   cycle_count  - cycles spent in RUN (saturating)
// ---------------------------------------------------------------------------
module halt_watchdog #(
    parameter int NUM_CH         = 2,
    parameter int ERR_W          = 16,
    parameter int CNT_W          = 32,
    parameter int ORD_W          = 64,
    parameter int TIMEOUT_CYCLES = 1000000000,
    parameter int STALL_CYCLES   = 10000,
    parameter int DRAIN_CYCLES   = 5,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [NUM_CH-1:0]       commit,
    input  logic [NUM_CH-1:0]       halt,
    input  logic [NUM_CH*ERR_W-1:0] errcode,
    output logic                    running,
    output logic                    done,
    output logic [2:0]              status,
    output logic [ERR_W-1:0]        err_code,
    output logic [CH_W-1:0]         err_ch,
    output logic [ORD_W-1:0]        commit_count,
    output logic [CNT_W-1:0]        cycle_count
);

    localparam logic [2:0] ST_NONE    = 3'd0;
    localparam logic [2:0] ST_HALT    = 3'd1;
    localparam logic [2:0] ST_TIMEOUT = 3'd2;
    localparam logic [2:0] ST_STALL   = 3'd3;
    localparam logic [2:0] ST_ERROR   = 3'd4;

    // Terminal compare values. A zero parameter wraps to all-ones here, but
    // the matching enable term below keeps that event disabled.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STALL_LAST   = CNT_W'(STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   drain_cnt;

    logic               any_commit;
    logic               any_halt;
    logic               err_hit;
    logic [ERR_W-1:0]   err_sel_code;
    logic [CH_W-1:0]    err_sel_ch;
    logic               stall_hit;
    logic               timeout_hit;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Saturating add for the committed-instruction counter.
    function automatic logic [ORD_W-1:0] sat_add_ord(input logic [ORD_W-1:0] a,
                                                     input logic [ORD_W-1:0] b);
        logic [ORD_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[ORD_W] ? {ORD_W{1'b1}} : sum[ORD_W-1:0];
    endfunction

    function automatic logic [ORD_W-1:0] popcount(input logic [NUM_CH-1:0] v);
        logic [ORD_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt = cnt + ORD_W'(v[i]);
        end
        return cnt;
    endfunction

    assign any_commit = |commit;
    assign any_halt   = |halt;

    // Scan from the highest channel down so the lowest erroring index is
    // the last one written and therefore wins.
    always_comb begin
        err_hit      = 1'b0;
        err_sel_code = '0;
        err_sel_ch   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (errcode[i*ERR_W +: ERR_W] != '0) begin
                err_hit      = 1'b1;
                err_sel_code = errcode[i*ERR_W +: ERR_W];
                err_sel_ch   = CH_W'(i);
            end
        end
    end

    // stall_cnt holds the number of commit-free cycles already seen, so a
    // match on STALL_LAST with no commit now is the STALL_CYCLES-th one.
    assign stall_hit   = (STALL_CYCLES != 0) && !any_commit && (stall_cnt == STALL_LAST);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cycle_count == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            running      <= 1'b0;
            done         <= 1'b0;
            status       <= ST_NONE;
            err_code     <= '0;
            err_ch       <= '0;
            commit_count <= '0;
            cycle_count  <= '0;
            stall_cnt    <= '0;
            drain_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end

                RUN: begin
                    // Counters advance on the terminating edge too, so the
                    // commits of a halting cycle are still accounted for.
                    cycle_count  <= sat_inc(cycle_count);
                    commit_count <= sat_add_ord(commit_count, popcount(commit));
                    stall_cnt    <= any_commit ? '0 : sat_inc(stall_cnt);

                    if (err_hit) begin
                        status    <= ST_ERROR;
                        err_code  <= err_sel_code;
                        err_ch    <= err_sel_ch;
                        running   <= 1'b0;
                        drain_cnt <= '0;
                        if (DRAIN_CYCLES == 0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (any_halt) begin
                        status  <= ST_HALT;
                        running <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else if (stall_hit) begin
                        status  <= ST_STALL;
                        running <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else if (timeout_hit) begin
                        status  <= ST_TIMEOUT;
                        running <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end

                DRAIN: begin
                    // Inputs are ignored here; the first error stays latched.
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + CNT_W'(1);
                    end
                end

                DONE: begin
                    // Terminal until reset; all outputs hold.
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_halt_watchdog.sv
// ---------------------------------------------------------------------------
// tb_halt_watchdog
//
// Directed bench for halt_watchdog. Two instances share the stimulus:
//   dut_a - TIMEOUT_CYCLES=50, STALL_CYCLES=8, DRAIN_CYCLES=5
//   dut_b - TIMEOUT_CYCLES=0,  STALL_CYCLES=0, DRAIN_CYCLES=0
// Expected output snapshots are queued when stimulus is applied and popped
// and compared once the DUT is due to show them.
// ---------------------------------------------------------------------------
module tb_halt_watchdog;

    localparam int NUM_CH = 2;
    localparam int ERR_W  = 16;
    localparam int CNT_W  = 32;
    localparam int ORD_W  = 64;

    logic                    clk;
    logic                    rst_n;
    logic                    start;
    logic [NUM_CH-1:0]       commit;
    logic [NUM_CH-1:0]       halt;
    logic [NUM_CH*ERR_W-1:0] errcode;

    logic                    running_a, done_a;
    logic [2:0]              status_a;
    logic [ERR_W-1:0]        err_code_a;
    logic [0:0]              err_ch_a;
    logic [ORD_W-1:0]        commit_count_a;
    logic [CNT_W-1:0]        cycle_count_a;

    logic                    running_b, done_b;
    logic [2:0]              status_b;
    logic [ERR_W-1:0]        err_code_b;
    logic [0:0]              err_ch_b;
    logic [ORD_W-1:0]        commit_count_b;
    logic [CNT_W-1:0]        cycle_count_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string            tag;
        bit               sel_b;
        logic             running;
        logic             done;
        logic [2:0]       status;
        logic [ERR_W-1:0] err_code;
        logic [0:0]       err_ch;
        logic [ORD_W-1:0] commit_count;
        logic [CNT_W-1:0] cycle_count;
    } exp_t;

    exp_t sb[$];

    halt_watchdog #(
        .NUM_CH(NUM_CH), .ERR_W(ERR_W), .CNT_W(CNT_W), .ORD_W(ORD_W),
        .TIMEOUT_CYCLES(50), .STALL_CYCLES(8), .DRAIN_CYCLES(5)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .commit(commit), .halt(halt),
        .errcode(errcode), .running(running_a), .done(done_a), .status(status_a),
        .err_code(err_code_a), .err_ch(err_ch_a), .commit_count(commit_count_a),
        .cycle_count(cycle_count_a)
    );

    halt_watchdog #(
        .NUM_CH(NUM_CH), .ERR_W(ERR_W), .CNT_W(CNT_W), .ORD_W(ORD_W),
        .TIMEOUT_CYCLES(0), .STALL_CYCLES(0), .DRAIN_CYCLES(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .commit(commit), .halt(halt),
        .errcode(errcode), .running(running_b), .done(done_b), .status(status_b),
        .err_code(err_code_b), .err_ch(err_ch_b), .commit_count(commit_count_b),
        .cycle_count(cycle_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n clock edges; inputs change and outputs are sampled 1ns after.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_push(input string tag, input bit sel_b, input logic running,
                               input logic done, input logic [2:0] status,
                               input logic [ERR_W-1:0] ec, input logic [0:0] ech,
                               input logic [ORD_W-1:0] cc, input logic [CNT_W-1:0] cyc);
        exp_t e;
        e.tag = tag; e.sel_b = sel_b; e.running = running; e.done = done;
        e.status = status; e.err_code = ec; e.err_ch = ech;
        e.commit_count = cc; e.cycle_count = cyc;
        sb.push_back(e);
    endtask

    task automatic expect_pop();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        if (!e.sel_b) begin
            chk({e.tag, ".running"},  64'(running_a),      64'(e.running));
            chk({e.tag, ".done"},     64'(done_a),         64'(e.done));
            chk({e.tag, ".status"},   64'(status_a),       64'(e.status));
            chk({e.tag, ".err_code"}, 64'(err_code_a),     64'(e.err_code));
            chk({e.tag, ".err_ch"},   64'(err_ch_a),       64'(e.err_ch));
            chk({e.tag, ".commits"},  commit_count_a,      e.commit_count);
            chk({e.tag, ".cycles"},   64'(cycle_count_a),  64'(e.cycle_count));
        end else begin
            chk({e.tag, ".running"},  64'(running_b),      64'(e.running));
            chk({e.tag, ".done"},     64'(done_b),         64'(e.done));
            chk({e.tag, ".status"},   64'(status_b),       64'(e.status));
            chk({e.tag, ".err_code"}, 64'(err_code_b),     64'(e.err_code));
            chk({e.tag, ".err_ch"},   64'(err_ch_b),       64'(e.err_ch));
            chk({e.tag, ".commits"},  commit_count_b,      e.commit_count);
            chk({e.tag, ".cycles"},   64'(cycle_count_b),  64'(e.cycle_count));
        end
    endtask

    task automatic do_reset();
        start   = 1'b0;
        commit  = '0;
        halt    = '0;
        errcode = '0;
        rst_n   = 1'b0;
        tick(2);
        rst_n   = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        commit  = '0;
        halt    = '0;
        errcode = '0;

        // ---- reset state ----
        tick(2);
        expect_push("reset_a", 1'b0, 0, 0, 3'd0, '0, '0, '0, '0);
        expect_push("reset_b", 1'b1, 0, 0, 3'd0, '0, '0, '0, '0);
        expect_pop();
        expect_pop();
        rst_n = 1'b1;

        // ---- idle ignores everything but start ----
        commit = 2'b11; halt = 2'b11; errcode = {16'h0001, 16'h0001};
        tick(3);
        expect_push("idle_hold", 1'b0, 0, 0, 3'd0, '0, '0, '0, '0);
        expect_pop();

        // ---- halt ----
        do_reset();
        do_start();
        expect_push("halt_run", 1'b0, 1, 0, 3'd0, '0, '0, '0, '0);
        expect_pop();
        commit = 2'b11;
        tick(10);
        halt = 2'b10;
        expect_push("halt_end", 1'b0, 0, 1, 3'd1, '0, '0, 64'd22, 32'd11);
        tick(1);
        halt = '0; commit = '0;
        expect_pop();
        start = 1'b1;
        tick(3);
        start = 1'b0;
        expect_push("halt_sticky", 1'b0, 0, 1, 3'd1, '0, '0, 64'd22, 32'd11);
        expect_pop();

        // ---- timeout ----
        do_reset();
        do_start();
        commit = 2'b01;
        tick(49);
        expect_push("timeout_pre", 1'b0, 1, 0, 3'd0, '0, '0, 64'd49, 32'd49);
        expect_pop();
        expect_push("timeout_end", 1'b0, 0, 1, 3'd2, '0, '0, 64'd50, 32'd50);
        tick(1);
        expect_pop();
        commit = '0;

        // ---- stall with a restarting commit ----
        do_reset();
        do_start();
        commit = 2'b11;
        tick(3);
        commit = '0;
        tick(5);
        commit = 2'b01;
        tick(1);
        commit = '0;
        tick(7);
        expect_push("stall_pre", 1'b0, 1, 0, 3'd0, '0, '0, 64'd7, 32'd16);
        expect_pop();
        expect_push("stall_end", 1'b0, 0, 1, 3'd3, '0, '0, 64'd7, 32'd17);
        tick(1);
        expect_pop();

        // ---- error with drain; error outranks halt; lowest channel wins ----
        do_reset();
        do_start();
        commit = 2'b01;
        tick(4);
        errcode = {16'h0003, 16'h0007};
        halt    = 2'b01;
        expect_push("err_latch", 1'b0, 0, 0, 3'd4, 16'h0007, 1'b0, 64'd5, 32'd5);
        tick(1);
        expect_pop();
        errcode = {16'h0009, 16'h0000};
        halt    = 2'b00;
        tick(1);
        halt    = 2'b10;
        tick(1);
        halt    = 2'b00;
        tick(2);
        expect_push("drain_mid", 1'b0, 0, 0, 3'd4, 16'h0007, 1'b0, 64'd5, 32'd5);
        expect_pop();
        expect_push("drain_done", 1'b0, 0, 1, 3'd4, 16'h0007, 1'b0, 64'd5, 32'd5);
        tick(1);
        expect_pop();
        halt = 2'b11;
        tick(2);
        halt = '0; errcode = '0; commit = '0;
        expect_push("done_hold", 1'b0, 0, 1, 3'd4, 16'h0007, 1'b0, 64'd5, 32'd5);
        expect_pop();

        // ---- asynchronous reset in the middle of drain ----
        do_reset();
        do_start();
        tick(2);
        errcode = {16'h0000, 16'h0001};
        tick(1);
        errcode = '0;
        tick(1);
        chk("drain_entered.status", 64'(status_a), 64'd4);
        #3;
        rst_n = 1'b0;
        #1;
        expect_push("async_reset", 1'b0, 0, 0, 3'd0, '0, '0, '0, '0);
        expect_pop();
        rst_n = 1'b1;
        tick(1);
        do_start();
        commit = 2'b01;
        tick(3);
        halt = 2'b01;
        expect_push("post_reset_halt", 1'b0, 0, 1, 3'd1, '0, '0, 64'd4, 32'd4);
        tick(1);
        halt = '0; commit = '0;
        expect_pop();

        // ---- disabled timeout/stall, zero drain ----
        do_reset();
        do_start();
        tick(1000);
        expect_push("disabled_run", 1'b1, 1, 0, 3'd0, '0, '0, '0, 32'd1000);
        expect_pop();
        errcode = {16'h00AB, 16'h0000};
        expect_push("zero_drain", 1'b1, 0, 1, 3'd4, 16'h00AB, 1'b1, '0, 32'd1001);
        tick(1);
        errcode = '0;
        expect_pop();

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/halt_watchdog.md
Name: halt_watchdog

Overview:
Parametrised run-control monitor that decides when a simulation run ends and why.
- Watches NUM_CH commit channels for halt, error codes, commit stalls and a global timeout.
- Latches a single terminal status.
- Applies a configurable drain delay after errors so the surrounding bench can finish cleanly.
- Sits beside the RVFI monitor in the testbench top and generalises the fixed single-channel halt/timeout/errcode logic to superscalar retire widths.

Parameters:
NUM_CH, 2, number of commit/retire channels monitored
ERR_W, 16, width of each per-channel error code
CNT_W, 32, width of cycle and stall counters
ORD_W, 64, width of the committed-instruction counter
TIMEOUT_CYCLES, 1000000000, run cycles before TIMEOUT; 0 disables
STALL_CYCLES, 10000, consecutive commit-free run cycles before STALL; 0 disables
DRAIN_CYCLES, 5, cycles spent in DRAIN after an error before done

Ports:
clk  input  1  single clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  one-cycle pulse; IDLE->RUN
commit  input  NUM_CH  per-channel commit valid
halt  input  NUM_CH  per-channel halt flag
errcode  input  NUM_CH*ERR_W  per-channel error codes; channel i at [i*ERR_W +: ERR_W]; nonzero = error
running  output  1  high in RUN
done  output  1  high in DONE, sticky until reset
status  output  3  0 NONE, 1 HALT, 2 TIMEOUT, 3 STALL, 4 ERROR
err_code  output  ERR_W  latched error code
err_ch  output  $clog2(NUM_CH) (min 1)  channel that raised the error
commit_count  output  ORD_W  total commits in RUN
cycle_count  output  CNT_W  cycles spent in RUN

Behaviour:
- States: IDLE, RUN, DRAIN, DONE.
- Reset, async on rst_n low:
  - state IDLE; all outputs 0.
  - Reset mid-operation aborts immediately from any state.
- IDLE:
  - start=1 -> RUN.
  - Counters are held at 0.
  - Inputs other than start are ignored.
- RUN, each posedge:
  - cycle_count += 1, saturating.
  - commit_count += popcount(commit).
  - stall counter clears on any commit bit, otherwise +1, saturating.
- Event detection in RUN on sampled inputs, priority ERROR > HALT > STALL > TIMEOUT:
  - ERROR: any errcode channel nonzero.
    - Lowest index wins; latch err_code/err_ch.
    - status=4 on next edge; go to DRAIN.
  - HALT: any halt bit set -> status=1, DONE on next edge.
    - Commits on the halting cycle are still counted.
  - STALL: stall counter == STALL_CYCLES-1 while no commit -> status=3, DONE.
    - Net effect: DONE after STALL_CYCLES commit-free cycles.
  - TIMEOUT: cycle_count == TIMEOUT_CYCLES-1 -> status=2, DONE.
    - TIMEOUT_CYCLES=1 ends after the first RUN cycle.
- DRAIN:
  - Internal counter runs 0..DRAIN_CYCLES-1, then DONE.
  - DRAIN_CYCLES=0: ERROR goes RUN->DONE directly.
  - commit_count/cycle_count frozen.
  - halt, further errcodes and start are ignored; the first error is sticky.
- DONE: terminal; outputs hold; start ignored until reset.
- Latency:
  - Event sampled at edge N -> status/done valid after edge N+1.
  - Error -> status=4 after N+1; done after N+1+DRAIN_CYCLES.
- Simultaneous events: the higher-priority event wins. Error+halt on the same edge reports ERROR and drains.
- Counter saturation at all-ones; no wrap.
- errcode is a flat vector; channel 0 occupies bits [ERR_W-1:0].

Test Plan:
- Halt: reset, start, 10 cycles with commit=2'b11, then halt[1]=1 -> done one cycle later, status=1, commit_count=22 (halting-cycle commits counted), cycle_count=11.
- Timeout: TIMEOUT_CYCLES=50, commit=2'b01 every cycle, no halt -> done after 50 RUN cycles, status=2, cycle_count=50, commit_count=50.
- Stall: STALL_CYCLES=8, commits for 3 cycles then none -> status=3 after the 8th commit-free cycle; a single commit on cycle 6 of a gap restarts the count.
- Error with drain: DRAIN_CYCLES=5, errcode ch1=16'h0003, ch0=16'h0007 on the same edge alongside halt[0]=1 -> status=4, err_ch=0, err_code=16'h0007; running low during drain; done exactly 5 cycles after status=4; later halt pulses have no effect.
- Reset mid-DRAIN: assert rst_n=0 asynchronously between edges -> all outputs 0 immediately; after release plus start, a new halt run reports status=1 with fresh counters.
- Disables and corner configs: TIMEOUT_CYCLES=0, STALL_CYCLES=0, no commits for 1000 cycles -> still running, status=0. With DRAIN_CYCLES=0, an error -> DONE one cycle after the error edge.
